// File: rtl/coprocessor_tx_serializer.sv
// Response-side serializer: buffers coprocessor result words and streams
// them as bytes (optionally terminated) over a valid/ready byte interface.
module coprocessor_tx_serializer #(
    parameter int          WIDTH_DOUT = 128,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MSB_FIRST  = 1,
    parameter int          TERM_EN    = 1,
    parameter logic [7:0]  TERM_BYTE  = 8'h0A
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH_DOUT-1:0]         dout,
    input  logic                          dout_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int NBYTES = WIDTH_DOUT / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2
    } state_t;

    logic [WIDTH_DOUT-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [WIDTH_DOUT-1:0] r_shift;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_ovf;

    logic                  w_xfer;
    logic                  w_fifo_ne;
    logic                  w_full;
    logic                  w_last;
    logic                  w_eow;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;
    logic [WIDTH_DOUT-1:0] w_head;
    logic [WIDTH_DOUT-1:0] w_shift_nxt;

    function automatic logic [7:0] first_byte(input logic [WIDTH_DOUT-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH_DOUT-1 -: 8] : w[7:0];
    endfunction

    assign w_xfer      = r_tx_valid & tx_ready;
    assign w_fifo_ne   = (r_level != '0);
    assign w_full      = (r_level == FULL_LVL);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_eow       = w_xfer & ((r_state == TERM) |
                         ((r_state == SEND) & w_last & (TERM_EN == 0)));
    // A pop always reloads the shift register, so back-to-back words stay gapless
    assign w_pop       = w_fifo_ne & ((r_state == IDLE) | w_eow);
    assign w_wr        = dout_valid & ~w_full;
    assign w_drop      = dout_valid & w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_shift_nxt = (MSB_FIRST != 0) ? (r_shift << 8) : (r_shift >> 8);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_overflow) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_shift    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_pop) begin
            r_shift    <= w_head;
            r_idx      <= '0;
            r_tx_data  <= first_byte(w_head);
            r_tx_valid <= 1'b1;
            r_state    <= SEND;
        end else if (w_eow) begin
            r_tx_valid <= 1'b0;
            r_state    <= IDLE;
        end else if ((r_state == SEND) && w_xfer) begin
            if (!w_last) begin
                r_idx     <= r_idx + IW'(1);
                r_shift   <= w_shift_nxt;
                r_tx_data <= first_byte(w_shift_nxt);
            end else begin
                r_tx_data <= TERM_BYTE;
                r_state   <= TERM;
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign fifo_level = r_level;
    assign overflow   = r_ovf;
    assign busy       = (r_state != IDLE) | w_fifo_ne;

endmodule

// File: tb/tb_coprocessor_tx_serializer.sv
// Bench for coprocessor_tx_serializer: directed table, corner sequences,
// and randomized traffic against a byte-queue reference model.
module tb_coprocessor_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] dout_a, dout_b;
    logic         dv_a, dv_b, rdy_a, rdy_b, clr_a, clr_b;
    logic [7:0]   txd_a, txd_b;
    logic         txv_a, txv_b, busy_a, busy_b, ovf_a, ovf_b;
    logic [1:0]   lvl_a, lvl_b;

    coprocessor_tx_serializer u_dut_a (
        .clk(clk), .rst_n(rst_n), .dout(dout_a), .dout_valid(dv_a),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(rdy_a),
        .busy(busy_a), .fifo_level(lvl_a), .overflow(ovf_a),
        .clr_overflow(clr_a)
    );

    coprocessor_tx_serializer #(.MSB_FIRST(0), .TERM_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .dout(dout_b), .dout_valid(dv_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(rdy_b),
        .busy(busy_b), .fifo_level(lvl_b), .overflow(ovf_b),
        .clr_overflow(clr_b)
    );

    int checks = 0;
    int passes = 0;
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic [7:0] exp_q[$];

    localparam logic [127:0] WA = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] WB = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
    localparam logic [127:0] WC = 128'h55AA33CC0FF0E11E96692BD47788A5C3;
    localparam logic [127:0] WD = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] WE = 128'h1234123412341234ABCDABCDABCDABCD;
    localparam logic [127:0] WR = 128'h0F0E0D0C0B0A09080706050403020100;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // Reference: a word becomes NBYTES bytes in send order, then the terminator
    task automatic push_word(input logic [127:0] w, input bit msb, input bit term);
        for (int k = 0; k < 16; k++)
            exp_q.push_back(msb ? w[8*(15-k) +: 8] : w[8*k +: 8]);
        if (term) exp_q.push_back(8'h0A);
    endtask

    task automatic cmp_q(input string n, input logic [7:0] g[$]);
        chk({n, "_len"}, 128'(g.size()), 128'(exp_q.size()));
        for (int i = 0; i < g.size() && i < exp_q.size(); i++)
            chk(n, g[i], exp_q[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       pv_a = 1'b0, pr_a = 1'b0;
    logic [7:0] pd_a = 8'h00;
    always @(posedge clk) begin
        if (rst_n) begin
            if (pv_a && !pr_a) begin
                chk("stall_valid", txv_a, 1'b1);
                chk("stall_data", txd_a, pd_a);
            end
            if (txv_a && rdy_a) got_a.push_back(txd_a);
            if (txv_b && rdy_b) got_b.push_back(txd_b);
        end
        pv_a <= txv_a && rst_n;
        pr_a <= rdy_a;
        pd_a <= txd_a;
    end

    typedef struct {
        logic         dv;
        logic         clr;
        logic [127:0] w;
        logic [1:0]   lvl;
        logic         ovf;
        logic         v;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int issued;
        int gaps;
        logic [127:0] w;

        rst_n = 1'b0;
        dout_a = '0; dout_b = '0;
        dv_a = 0; dv_b = 0; rdy_a = 0; rdy_b = 0; clr_a = 0; clr_b = 0;
        tick(); tick();
        chk("rst_valid", txv_a, 1'b0);
        chk("rst_data", txd_a, 8'h00);
        chk("rst_level", lvl_a, 2'd0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_ovf", ovf_a, 1'b0);
        chk("rst_valid_b", txv_b, 1'b0);
        rst_n = 1'b1;
        tick();

        // single word, ready always high
        exp_q.delete();
        push_word(WA, 1, 1);
        rdy_a = 1; dout_a = WA; dv_a = 1;
        tick();
        dv_a = 0;
        chk("lat_c1_valid", txv_a, 1'b0);
        chk("lat_c1_level", lvl_a, 2'd1);
        tick();
        for (int k = 0; k < 17; k++) begin
            chk("t1_valid", txv_a, 1'b1);
            chk("t1_byte", txd_a, exp_q[k]);
            tick();
        end
        chk("t1_done_valid", txv_a, 1'b0);
        chk("t1_done_busy", busy_a, 1'b0);

        // same word, ready pattern 1,0,0 repeating
        got_a.delete();
        for (int c = 0; c < 300; c++) begin
            rdy_a = (c % 3 == 0);
            dv_a = (c == 0);
            tick();
            if (got_a.size() == 17 && !txv_a) break;
        end
        dv_a = 0;
        cmp_q("t2_stream", got_a);
        chk("t2_busy", busy_a, 1'b0);

        // overflow table, ready held low
        tbl[0] = '{1, 0, WA, 2'd1, 0, 0};
        tbl[1] = '{1, 0, WB, 2'd1, 0, 1};
        tbl[2] = '{1, 0, WC, 2'd2, 0, 1};
        tbl[3] = '{1, 0, WD, 2'd2, 1, 1};
        tbl[4] = '{1, 1, WE, 2'd2, 1, 1};
        tbl[5] = '{0, 1, '0, 2'd2, 0, 1};
        tbl[6] = '{0, 0, '0, 2'd2, 0, 1};
        rdy_a = 0;
        for (int i = 0; i < 7; i++) begin
            dv_a = tbl[i].dv; clr_a = tbl[i].clr; dout_a = tbl[i].w;
            tick();
            chk($sformatf("tbl%0d_level", i), lvl_a, tbl[i].lvl);
            chk($sformatf("tbl%0d_ovf", i), ovf_a, tbl[i].ovf);
            chk($sformatf("tbl%0d_valid", i), txv_a, tbl[i].v);
        end
        dv_a = 0; clr_a = 0;
        chk("tbl_head_byte", txd_a, 8'h00);

        got_a.delete();
        exp_q.delete();
        push_word(WA, 1, 1); push_word(WB, 1, 1); push_word(WC, 1, 1);
        rdy_a = 1;
        gaps = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (got_a.size() > 0 && got_a.size() < 51 && !txv_a) gaps++;
            if (got_a.size() >= 51 && !txv_a) break;
        end
        chk("t3_gapless", 128'(gaps), 128'd0);
        cmp_q("t3_stream", got_a);
        chk("t3_level", lvl_a, 2'd0);
        chk("t3_busy", busy_a, 1'b0);
        chk("t3_ovf", ovf_a, 1'b0);

        // LSB-first, no terminator
        exp_q.delete();
        push_word(WR, 0, 0);
        rdy_b = 1; dout_b = WR; dv_b = 1;
        tick();
        dv_b = 0;
        for (int c = 0; c < 60 && !(got_b.size() == 16 && !txv_b); c++) tick();
        repeat (3) tick();
        cmp_q("t5_stream", got_b);
        chk("t5_valid", txv_b, 1'b0);
        chk("t5_busy", busy_b, 1'b0);

        // reset mid-word with one word queued
        got_a.delete();
        rdy_a = 1; dout_a = WB; dv_a = 1;
        tick();
        dout_a = WC;
        tick();
        dv_a = 0;
        for (int c = 0; c < 60 && got_a.size() < 5; c++) tick();
        chk("t6_pre_level", lvl_a, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", txv_a, 1'b0);
        chk("t6_rst_level", lvl_a, 2'd0);
        chk("t6_rst_busy", busy_a, 1'b0);
        chk("t6_rst_data", txd_a, 8'h00);
        #3 rst_n = 1'b1;
        repeat (20) tick();
        chk("t6_no_more_bytes", 128'(got_a.size()), 128'd5);
        got_a.delete();
        exp_q.delete();
        push_word(WE, 1, 1);
        dout_a = WE; dv_a = 1;
        tick();
        dv_a = 0;
        for (int c = 0; c < 60 && !(got_a.size() == 17 && !txv_a); c++) tick();
        cmp_q("t6_fresh", got_a);

        // randomized traffic, never more words outstanding than the FIFO holds
        got_a.delete();
        exp_q.delete();
        issued = 0;
        for (int c = 0; c < 20000; c++) begin
            rdy_a = ($urandom_range(0, 9) < 7);
            if (issued < 40 && (issued - got_a.size() / 17) < 2 &&
                $urandom_range(0, 2) == 0) begin
                w = {$urandom, $urandom, $urandom, $urandom};
                dout_a = w; dv_a = 1;
                push_word(w, 1, 1);
                issued++;
            end else begin
                dv_a = 0;
            end
            tick();
            if (issued == 40 && got_a.size() == exp_q.size() && !busy_a) break;
        end
        dv_a = 0;
        cmp_q("rand_stream", got_a);
        chk("rand_ovf", ovf_a, 1'b0);
        chk("rand_busy", busy_a, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
